// File: rtl/lcd_pkg.sv
// lcd_pkg: shared LCD geometry, clock constant and arbiter state encoding.
package lcd_pkg;
  localparam int LCD_CHARS = 32;
  localparam int LCD_LINE_LEN = 16;
  localparam int LCD_POS_W = 5;
  localparam int LCD_RAM_AW = 10;
  localparam int CLK_FREQ = 50_000_000;
  typedef enum logic {IDLE, BURST} state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr_i with wrap-around.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] grant_o
);
  int idx;
  // Walk from the farthest offset down so the nearest request overwrites the rest.
  always_comb begin
    grant_o = '0;
    idx = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(ptr_i) + i) % NUM_REQ;
      if (req_i[idx]) grant_o = NUM_REQ'(1) << idx;
    end
  end
endmodule

// File: rtl/lcd_frame_arbiter.sv
// lcd_frame_arbiter: round-robin burst owner of the LCD display RAM write port,
// with a no-progress watchdog and a write-idle standby request.
module lcd_frame_arbiter
  import lcd_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDLE_CYCLES = 250_000_000,
  parameter int WDOG_CYCLES = 1024,
  parameter int TIMER_W = 28
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [NUM_REQ-1:0]             i_req,
  input  logic [NUM_REQ-1:0]             i_valid,
  input  logic [NUM_REQ-1:0]             i_last,
  input  logic [NUM_REQ*LCD_POS_W-1:0]   i_addr,
  input  logic [NUM_REQ*8-1:0]           i_data,
  output logic [NUM_REQ-1:0]             o_grant,
  output logic [NUM_REQ-1:0]             o_ack,
  output logic                           o_wr_en,
  output logic [LCD_RAM_AW-1:0]          o_wr_addr,
  output logic [7:0]                     o_wr_data,
  input  logic                           i_lcd_ready,
  output logic                           o_standby
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  state_e state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d, win, ack;
  logic [PW-1:0] ptr_q, ptr_d, win_idx;
  logic [WW-1:0] wdog_q, wdog_d;
  logic [TIMER_W-1:0] idle_q, idle_d;
  logic wr_en_q, wr_en_d, sel_last;
  logic [LCD_POS_W-1:0] addr_q, addr_d, sel_addr;
  logic [7:0] data_q, data_d, sel_data;
  rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_rr (
    .req_i(i_req), .ptr_i(ptr_q), .grant_o(win)
  );
  assign ack = grant_q & i_valid;
  assign sel_last = |(ack & i_last);
  // Grant is one-hot, so OR-ing masked lanes yields the owner's lane.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    win_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sel_addr = sel_addr | (ack[k] ? i_addr[LCD_POS_W*k +: LCD_POS_W] : '0);
      sel_data = sel_data | (ack[k] ? i_data[8*k +: 8] : '0);
      if (win[k]) win_idx = PW'(k);
    end
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d = ptr_q;
    wdog_d = wdog_q;
    wr_en_d = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (state_q == IDLE) begin
      if (|i_req && i_lcd_ready) begin
        state_d = BURST;
        grant_d = win;
        ptr_d = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
      end
    end else if (|ack) begin
      wr_en_d = 1'b1;
      addr_d = sel_addr;
      data_d = sel_data;
      wdog_d = '0;
      if (sel_last) begin
        state_d = IDLE;
        grant_d = '0;
      end
    end else if (wdog_q == WW'(WDOG_CYCLES - 1)) begin
      state_d = IDLE;
      grant_d = '0;
      wdog_d = '0;
    end else begin
      wdog_d = wdog_q + 1'b1;
    end
  end
  assign idle_d = wr_en_q ? '0 : (o_standby ? idle_q : idle_q + 1'b1);
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q <= '0;
      wdog_q <= '0;
      idle_q <= '0;
      wr_en_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q <= ptr_d;
      wdog_q <= wdog_d;
      idle_q <= idle_d;
      wr_en_q <= wr_en_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end
  assign o_grant = grant_q;
  assign o_ack = ack;
  assign o_wr_en = wr_en_q;
  assign o_wr_addr = {{(LCD_RAM_AW - LCD_POS_W){1'b0}}, addr_q};
  assign o_wr_data = data_q;
  assign o_standby = (idle_q == TIMER_W'(IDLE_CYCLES));
endmodule

// File: tb/tb_lcd_frame_arbiter.sv
// tb_lcd_frame_arbiter: directed vectors with hand-computed expectations for lcd_frame_arbiter.
module tb_lcd_frame_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req = '0, valid = '0, last = '0;
  logic [19:0] addr = '0;
  logic [31:0] data = '0;
  logic ready = 1'b0;
  logic [3:0] grant, ack;
  logic wr_en, standby;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  int n_chk = 0;
  int n_fail = 0;
  logic bad;
  lcd_frame_arbiter #(.NUM_REQ(4), .IDLE_CYCLES(100), .WDOG_CYCLES(1024), .TIMER_W(28)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_valid(valid), .i_last(last),
    .i_addr(addr), .i_data(data), .o_grant(grant), .o_ack(ack), .o_wr_en(wr_en),
    .o_wr_addr(wr_addr), .o_wr_data(wr_data), .i_lcd_ready(ready), .o_standby(standby)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic lane(input int k, input logic v, input logic l, input logic [4:0] a, input logic [7:0] d);
    valid[k] = v;
    last[k] = l;
    addr[5*k +: 5] = a;
    data[8*k +: 8] = d;
  endtask
  task automatic clear();
    req = '0;
    valid = '0;
    last = '0;
    addr = '0;
    data = '0;
  endtask
  initial begin
    step();
    step();
    check("rst_grant", grant, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_addr", wr_addr, 0);
    check("rst_data", wr_data, 0);
    check("rst_standby", standby, 0);
    check("rst_ack", ack, 0);
    rst = 1'b0;
    repeat (99) step();
    check("stby_99", standby, 0);
    step();
    check("stby_100", standby, 1);
    step();
    check("stby_sat", standby, 1);
    ready = 1'b1;
    req = 4'b0001;
    lane(2, 1'b1, 1'b1, 5'd9, 8'hEE);
    step();
    check("hi_grant", grant, 4'b0001);
    check("hi_ack_idle_lane", ack, 0);
    lane(0, 1'b1, 1'b0, 5'd0, 8'h48);
    #1;
    check("hi_ack", ack, 4'b0001);
    step();
    check("hi_wr0_en", wr_en, 1);
    check("hi_wr0_addr", wr_addr, 10'h000);
    check("hi_wr0_data", wr_data, 8'h48);
    check("hi_grant_held", grant, 4'b0001);
    check("hi_stby_during", standby, 1);
    lane(0, 1'b1, 1'b1, 5'd1, 8'h49);
    step();
    check("hi_wr1_en", wr_en, 1);
    check("hi_wr1_addr", wr_addr, 10'h001);
    check("hi_wr1_data", wr_data, 8'h49);
    check("hi_release", grant, 0);
    check("hi_stby_drop", standby, 0);
    clear();
    step();
    check("hi_wr_end", wr_en, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b1111;
    valid = 4'b1111;
    last = 4'b1111;
    addr = {5'd7, 5'd6, 5'd5, 5'd4};
    data = 32'h44434241;
    for (int r = 0; r < 5; r++) begin
      step();
      check("rr_grant", grant, 32'(1) << (r % 4));
      step();
      check("rr_dead", grant, 0);
      check("rr_wr_en", wr_en, 1);
      check("rr_wr_data", wr_data, 32'h41 + (r % 4));
      check("rr_wr_addr", wr_addr, 32'h4 + (r % 4));
    end
    clear();
    step();
    ready = 1'b0;
    req = 4'b0010;
    bad = 1'b0;
    repeat (3) begin
      step();
      if (grant !== 4'b0000) bad = 1'b1;
    end
    check("gate_no_grant", bad, 0);
    ready = 1'b1;
    step();
    check("gate_grant", grant, 4'b0010);
    for (int i = 0; i < 16; i++) begin
      lane(1, 1'b1, i == 15, 5'(i), 8'(8'h60 + i));
      if (i == 1) ready = 1'b0;
      step();
      check("gate_wr_en", wr_en, 1);
      check("gate_wr_addr", wr_addr, i);
      check("gate_wr_data", wr_data, 32'h60 + i);
      check("gate_grant_burst", grant, (i == 15) ? 0 : 4'b0010);
    end
    clear();
    step();
    ready = 1'b1;
    req = 4'b0100;
    step();
    check("wd_grant", grant, 4'b0100);
    req = 4'b1100;
    bad = 1'b0;
    repeat (1023) begin
      step();
      if (grant !== 4'b0100 || wr_en !== 1'b0) bad = 1'b1;
    end
    check("wd_hold", bad, 0);
    step();
    check("wd_release", grant, 0);
    check("wd_no_write", wr_en, 0);
    step();
    check("wd_next_grant", grant, 4'b1000);
    lane(3, 1'b1, 1'b1, 5'd31, 8'h5A);
    step();
    check("wd_req3_wr", wr_en, 1);
    check("wd_req3_addr", wr_addr, 10'h01F);
    check("wd_req3_data", wr_data, 8'h5A);
    check("wd_req3_release", grant, 0);
    clear();
    step();
    req = 4'b0010;
    step();
    check("mid_grant", grant, 4'b0010);
    for (int i = 0; i < 5; i++) begin
      lane(1, 1'b1, 1'b0, 5'(i), 8'(8'h30 + i));
      if (i == 4) rst = 1'b1;
      step();
    end
    check("mid_rst_grant", grant, 0);
    check("mid_rst_wr_en", wr_en, 0);
    check("mid_rst_addr", wr_addr, 0);
    check("mid_rst_data", wr_data, 0);
    check("mid_rst_ack", ack, 0);
    check("mid_rst_stby", standby, 0);
    rst = 1'b0;
    clear();
    req = 4'b0011;
    step();
    check("mid_after_grant", grant, 4'b0001);
    check("mid_after_wr", wr_en, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
